// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// counter sizing helper and the divide-by-zero quotient fill value.
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Every quotient bit is 1 on a divide by zero, whatever the width.
  localparam logic DBZ_QBIT = 1'b1;

  // Bits needed to count 0..v-1; at least one bit so a counter always exists.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r++;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor, keeping the result if non-negative.
module div_step #(
  parameter int w = 9
) (
  input  logic [w-1:0] r,
  input  logic         q_msb,
  input  logic [w-2:0] d,
  output logic [w-1:0] r_next,
  output logic         q_bit
);

  logic [w-1:0] r_shift;
  logic [w-1:0] diff;

  assign r_shift = {r[w-2:0], q_msb};
  // The extra top bit of the partial remainder acts as the borrow/sign bit.
  assign diff    = r_shift - {1'b0, d};
  assign q_bit   = ~diff[w-1];
  assign r_next  = q_bit ? diff : r_shift;

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one conditional-subtract step per
// clock, start/busy/done handshake, results held until the next completion.
module seq_divider
  import div_pkg::*;
#(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [n-1:0] dividend,
  input  logic [n-1:0] divisor,
  output logic [n-1:0] quotient,
  output logic [n-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam int            CW    = clog2(n);
  localparam logic [CW-1:0] LAST  = CW'(n - 1);
  localparam logic [n-1:0]  DBZ_Q = {n{DBZ_QBIT}};

  state_t         state;
  logic [n-1:0]   q_reg;
  logic [n-1:0]   d_reg;
  logic [n:0]     r_reg;
  logic [CW-1:0]  count;

  logic [n:0]     r_next;
  logic           q_bit;
  logic [n-1:0]   q_next;

  div_step #(
    .w(n + 1)
  ) u_step (
    .r      (r_reg),
    .q_msb  (q_reg[n-1]),
    .d      (d_reg),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

  assign q_next = {q_reg[n-2:0], q_bit};

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others, as real flops do.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      q_reg       <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            q_reg <= dividend;
            d_reg <= divisor;
            r_reg <= '0;
            count <= '0;
            busy  <= 1'b1;
            if (divisor == '0) begin
              // Nothing to iterate: publish the fixed divide-by-zero result now.
              quotient    <= DBZ_Q;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= ST_DONE;
            end else begin
              state <= ST_RUN;
            end
          end
        end

        ST_RUN: begin
          q_reg <= q_next;
          r_reg <= r_next;
          count <= count + CW'(1);
          if (count == LAST) begin
            quotient    <= q_next;
            remainder   <= r_next[n-1:0];
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            state       <= ST_DONE;
          end
        end

        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
